// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARMv8 pipeline stages.
package arm_pipe_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned INSN_W = 32;

   localparam logic [INSN_W-1:0] NOP_INSN = 32'hD503201F;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with hold / +4 / redirect next-pc selection.
module fetch_pc_gen
   import arm_pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            inc,
   input  logic            load,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_next;

   // Redirect wins over increment; targets are forced word aligned.
   always_comb begin
      pc_next = pc;
      if (load) begin
         pc_next = redirect_pc & ~XLEN'(3);
      end else if (inc) begin
         pc_next = pc + XLEN'(4);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, single-entry buffer
// feeding IF/ID, with bubbles on empty buffer or redirect squash.
module if_fetch_unit
   import arm_pipe_pkg::*;
#(
   parameter logic [XLEN-1:0]   RESET_PC = 64'h0,
   parameter logic [INSN_W-1:0] NOP_INSN = arm_pipe_pkg::NOP_INSN
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ack,
   input  logic [INSN_W-1:0] imem_rdata,
   output logic              if_wren,
   output logic [XLEN-1:0]   if_pc,
   output logic [XLEN-1:0]   if_pc_link,
   output logic [INSN_W-1:0] if_instruction
);

   fetch_state_e      state;
   fetch_state_e      state_next;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   buf_pc;
   logic [INSN_W-1:0] buf_insn;
   logic              pc_inc;
   logic              pc_load;
   logic              buf_load;
   logic              show;

   fetch_pc_gen #(
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clock       (clock),
      .reset       (reset),
      .inc         (pc_inc),
      .load        (pc_load),
      .redirect_pc (redirect_pc),
      .pc          (pc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      buf_load   = 1'b0;
      case (state)
         BOOT: begin
            state_next = REQ;
         end
         REQ: begin
            pc_load = redirect;
            if (imem_ack) begin
               buf_load   = !redirect;
               pc_inc     = !redirect;
               state_next = redirect ? REQ : FULL;
            end else if (redirect) begin
               state_next = DRAIN;
            end
         end
         FULL: begin
            pc_load = redirect;
            if (redirect || !stall) begin
               state_next = REQ;
            end
         end
         DRAIN: begin
            // Later redirects only retarget pc; the stale response is still owed.
            pc_load = redirect;
            if (imem_ack) begin
               state_next = REQ;
            end
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // addr_q remembers the in-flight address so DRAIN keeps it stable after pc moves.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         buf_insn <= NOP_INSN;
         buf_pc   <= '0;
         addr_q   <= '0;
      end else begin
         if (buf_load) begin
            buf_insn <= imem_rdata;
            buf_pc   <= pc;
         end
         if (state == REQ) begin
            addr_q <= pc;
         end
      end
   end

   assign imem_req  = (state == REQ) || (state == DRAIN);
   assign imem_addr = (state == DRAIN) ? addr_q :
                      (state == REQ)   ? pc     : '0;

   assign show           = (state == FULL) && !redirect;
   assign if_instruction = show ? buf_insn : NOP_INSN;
   assign if_pc          = show ? buf_pc : '0;
   assign if_pc_link     = show ? buf_pc + XLEN'(4) : '0;
   assign if_wren        = (state != BOOT) && (redirect || !stall);

endmodule
